// File: rtl/pkt_fifo_pkg.sv
// Shared types and helpers for the store-and-forward packet FIFO.
package pkt_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PKT     = 2'd1,
      DISCARD = 2'd2
   } wr_state_e;

   // Sideband half of the storage word; the top appends {mod, data}.
   typedef struct packed {
      logic sop;
      logic eop;
      logic err;
   } pkt_flags_t;

   function automatic int mod_w(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module pkt_fifo_ram #(
   parameter int W     = 72,
   parameter int DEPTH = 512,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/pkt_sf_fifo.sv
// Store-and-forward packet FIFO: whole packets become readable only after a
// clean eop; errored, restarted and overflowing packets are rolled back.
module pkt_sf_fifo import pkt_fifo_pkg::*; #(
   parameter int DATA_W      = 64,
   parameter int MOD_W       = mod_w(DATA_W),
   parameter int DEPTH       = 512,
   parameter int FULL_MARGIN = 4,
   parameter bit DROP_ERR    = 1'b1
) (
   input  logic              clk_156m25,
   input  logic              reset_156m25_n,
   input  logic              in_val,
   input  logic              in_sop,
   input  logic              in_eop,
   input  logic [MOD_W-1:0]  in_mod,
   input  logic              in_err,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_full,
   input  logic              out_ren,
   output logic              out_avail,
   output logic              out_val,
   output logic              out_sop,
   output logic              out_eop,
   output logic [MOD_W-1:0]  out_mod,
   output logic              out_err,
   output logic [DATA_W-1:0] out_data,
   output logic [31:0]       drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
   localparam logic [PW-1:0] MARGIN_P = PW'(FULL_MARGIN);
   localparam logic [PW-1:0] ONE_P    = PW'(1);

   typedef struct packed {
      pkt_flags_t        flg;
      logic [MOD_W-1:0]  mod;
      logic [DATA_W-1:0] data;
   } word_t;

   wr_state_e         r_state, w_state_n;
   logic [PW-1:0]     r_wr_ptr, r_wr_commit, r_rd_ptr, r_pkt_cnt;
   logic [PW-1:0]     w_wr_ptr_n, w_wr_commit_n, w_rd_ptr_n, w_pkt_cnt_n;
   logic [PW-1:0]     w_base;
   logic              w_room, w_start, w_we, w_commit;
   logic [AW-1:0]     w_waddr;
   logic [1:0]        w_drop_n;
   logic [32:0]       w_drop_sum;
   logic [31:0]       r_drop_cnt;
   logic              r_in_full, r_out_avail, r_out_val;
   logic              w_rd_ok, w_rd_eop;
   logic [DEPTH-1:0]  r_eop_flag;
   word_t             w_wword, w_rword;

   // A restart rebuilds from the committed pointer; otherwise append at wr_ptr.
   // One slot is always kept spare, so a DEPTH-word packet can never commit.
   always_comb begin
      w_state_n     = r_state;
      w_wr_ptr_n    = r_wr_ptr;
      w_wr_commit_n = r_wr_commit;
      w_we          = 1'b0;
      w_waddr       = r_wr_ptr[AW-1:0];
      w_commit      = 1'b0;
      w_drop_n      = 2'd0;
      w_base        = (r_state == PKT && !in_sop) ? r_wr_ptr : r_wr_commit;
      w_room        = (DEPTH_P - (w_base - r_rd_ptr)) > ONE_P;
      w_start       = in_val && ((r_state == IDLE && in_sop) || r_state == PKT);
      case (r_state)
         DISCARD: if (in_val && in_eop) w_state_n = IDLE;
         default: if (w_start) begin
            if (r_state == PKT && in_sop) w_drop_n = 2'd1;
            if (!w_room) begin
               w_wr_ptr_n = r_wr_commit;
               w_drop_n   = w_drop_n + 2'd1;
               w_state_n  = in_eop ? IDLE : DISCARD;
            end else begin
               w_we    = 1'b1;
               w_waddr = w_base[AW-1:0];
               if (!in_eop) begin
                  w_wr_ptr_n = w_base + ONE_P;
                  w_state_n  = PKT;
               end else if (DROP_ERR && in_err) begin
                  w_wr_ptr_n = r_wr_commit;
                  w_drop_n   = w_drop_n + 2'd1;
                  w_state_n  = IDLE;
               end else begin
                  w_wr_ptr_n    = w_base + ONE_P;
                  w_wr_commit_n = w_base + ONE_P;
                  w_commit      = 1'b1;
                  w_state_n     = IDLE;
               end
            end
         end
      endcase
   end

   assign w_wword.flg.sop = in_sop;
   assign w_wword.flg.eop = in_eop;
   assign w_wword.flg.err = DROP_ERR ? 1'b0 : (in_err & in_eop);
   assign w_wword.mod     = in_mod;
   assign w_wword.data    = in_data;

   // eop flags kept in flops so pkt_cnt can drop in the ren cycle itself.
   assign w_rd_ok     = out_ren && (r_rd_ptr != r_wr_commit);
   assign w_rd_eop    = w_rd_ok && r_eop_flag[r_rd_ptr[AW-1:0]];
   assign w_rd_ptr_n  = w_rd_ok ? r_rd_ptr + ONE_P : r_rd_ptr;
   assign w_pkt_cnt_n = r_pkt_cnt + PW'(w_commit) - PW'(w_rd_eop);
   assign w_drop_sum  = {1'b0, r_drop_cnt} + {31'd0, w_drop_n};

   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_wr_commit <= '0;
         r_rd_ptr    <= '0;
         r_pkt_cnt   <= '0;
         r_drop_cnt  <= '0;
         r_in_full   <= 1'b0;
         r_out_avail <= 1'b0;
         r_out_val   <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_wr_ptr    <= w_wr_ptr_n;
         r_wr_commit <= w_wr_commit_n;
         r_rd_ptr    <= w_rd_ptr_n;
         r_pkt_cnt   <= w_pkt_cnt_n;
         r_drop_cnt  <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
         r_in_full   <= (DEPTH_P - (w_wr_ptr_n - w_rd_ptr_n)) <= MARGIN_P;
         r_out_avail <= (w_pkt_cnt_n != '0);
         r_out_val   <= w_rd_ok;
      end
   end

   always_ff @(posedge clk_156m25) begin
      if (w_we) r_eop_flag[w_waddr] <= in_eop;
   end

   pkt_fifo_ram #(
      .W     ($bits(word_t)),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .i_clk   (clk_156m25),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wword),
      .i_re    (w_rd_ok),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (w_rword)
   );

   assign in_full   = r_in_full;
   assign out_avail = r_out_avail;
   assign out_val   = r_out_val;
   assign out_sop   = r_out_val & w_rword.flg.sop;
   assign out_eop   = r_out_val & w_rword.flg.eop;
   assign out_err   = r_out_val & w_rword.flg.err;
   assign out_mod   = r_out_val ? w_rword.mod : '0;
   assign out_data  = r_out_val ? w_rword.data : '0;
   assign drop_cnt  = r_drop_cnt;

endmodule
